// File: rtl/eeg_pea_feed.sv
// eeg_pea_feed: pairs each column's activation with its PE_ROW weight lanes
// and queues the pairs in per-PE first-word-fall-through FIFOs.
// Ports: CFG_* start/row mask/group count; IS_IDLE, DONE, ERR_LST status;
//   ACT_* per-column and WEI_* per-lane (lane c*PE_ROW+r) input streams;
//   PE_* per-PE FIFO head fields, popped on PE_DIN_VLD & PE_DIN_RDY.
module eeg_pea_feed #(
    parameter int PE_ROW     = 4,
    parameter int PE_COL     = 4,
    parameter int ACT_DW     = 8,
    parameter int WEI_DW     = 8,
    parameter int ACT_IW     = 12,
    parameter int WEI_IW     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int GRP_DW     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            CFG_START,
    input  logic [PE_ROW-1:0]               CFG_ROW_EN,
    input  logic [GRP_DW-1:0]               CFG_GRP_NUM,
    output logic                            IS_IDLE,
    output logic                            DONE,
    output logic                            ERR_LST,
    input  logic [PE_COL-1:0]               ACT_VLD,
    output logic [PE_COL-1:0]               ACT_RDY,
    input  logic [PE_COL-1:0]               ACT_LST,
    input  logic [PE_COL*ACT_DW-1:0]        ACT_DAT,
    input  logic [PE_COL*ACT_IW-1:0]        ACT_INF,
    input  logic [PE_COL*PE_ROW-1:0]        WEI_VLD,
    output logic [PE_COL*PE_ROW-1:0]        WEI_RDY,
    input  logic [PE_COL*PE_ROW-1:0]        WEI_LST,
    input  logic [PE_COL*PE_ROW*WEI_DW-1:0] WEI_DAT,
    input  logic [PE_COL*PE_ROW*WEI_IW-1:0] WEI_INF,
    output logic [PE_COL*PE_ROW-1:0]        PE_DIN_VLD,
    input  logic [PE_COL*PE_ROW-1:0]        PE_DIN_RDY,
    output logic [PE_COL*PE_ROW*ACT_DW-1:0] PE_ACT_DAT,
    output logic [PE_COL*PE_ROW*WEI_DW-1:0] PE_WEI_DAT,
    output logic [PE_COL*PE_ROW*ACT_IW-1:0] PE_ACT_INF,
    output logic [PE_COL*PE_ROW*WEI_IW-1:0] PE_WEI_INF,
    output logic [PE_COL*PE_ROW-1:0]        PE_LST
);

    localparam int PE_N = PE_COL * PE_ROW;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = 1 + WEI_IW + ACT_IW + WEI_DW + ACT_DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [PE_ROW-1:0] row_en;
    logic [GRP_DW-1:0] grp_num;
    logic [GRP_DW-1:0] grp_cnt [PE_COL];
    logic [PE_COL-1:0] col_done, fire, lst_bad;
    logic [PE_N-1:0]   push, pop, full, empty;
    logic [EW-1:0]     din [PE_N];
    logic [EW-1:0]     mem [PE_N][FIFO_DEPTH];
    logic [AW-1:0]     wptr [PE_N];
    logic [AW-1:0]     rptr [PE_N];
    logic [AW:0]       cnt [PE_N];
    logic              start, run;

    assign start   = (state == S_IDLE) && CFG_START;
    assign run     = (state == S_RUN);
    assign IS_IDLE = (state == S_IDLE);

    // Disabled rows are forced "ready" in the AND-reductions so they never
    // stall the column; a zero mask must not fire at all.
    for (genvar c = 0; c < PE_COL; c++) begin : g_col
        logic [PE_ROW-1:0] en_vld, en_room, en_lst;
        assign en_vld  = WEI_VLD[c*PE_ROW +: PE_ROW] | ~row_en;
        assign en_room = ~full[c*PE_ROW +: PE_ROW] | ~row_en;
        assign en_lst  = (WEI_LST[c*PE_ROW +: PE_ROW]
                         ^ {PE_ROW{ACT_LST[c]}}) & row_en;
        assign fire[c] = run && !col_done[c] && (|row_en) && ACT_VLD[c]
                         && (&en_vld) && (&en_room);
        assign lst_bad[c] = fire[c] && (|en_lst);
        assign ACT_RDY[c] = fire[c];
        assign WEI_RDY[c*PE_ROW +: PE_ROW] = {PE_ROW{fire[c]}} & row_en;
        for (genvar r = 0; r < PE_ROW; r++) begin : g_row
            localparam int I = c * PE_ROW + r;
            assign push[I] = fire[c] && row_en[r];
            assign din[I]  = {ACT_LST[c],
                              WEI_INF[I*WEI_IW +: WEI_IW],
                              ACT_INF[c*ACT_IW +: ACT_IW],
                              WEI_DAT[I*WEI_DW +: WEI_DW],
                              ACT_DAT[c*ACT_DW +: ACT_DW]};
        end
    end

    for (genvar i = 0; i < PE_N; i++) begin : g_pe
        logic [EW-1:0] head;
        assign empty[i]      = (cnt[i] == '0);
        assign full[i]       = (cnt[i] == (AW+1)'(FIFO_DEPTH));
        assign pop[i]        = !empty[i] && PE_DIN_RDY[i];
        assign PE_DIN_VLD[i] = !empty[i];
        assign head          = mem[i][rptr[i]];
        assign {PE_LST[i],
                PE_WEI_INF[i*WEI_IW +: WEI_IW],
                PE_ACT_INF[i*ACT_IW +: ACT_IW],
                PE_WEI_DAT[i*WEI_DW +: WEI_DW],
                PE_ACT_DAT[i*ACT_DW +: ACT_DW]} = head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PE_N; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < PE_N; i++) begin
                if (push[i]) begin
                    mem[i][wptr[i]] <= din[i];
                    wptr[i]         <= wptr[i] + 1'b1;
                end
                if (pop[i]) rptr[i] <= rptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            row_en   <= '0;
            grp_num  <= '0;
            ERR_LST  <= 1'b0;
            col_done <= '0;
            for (int c = 0; c < PE_COL; c++) grp_cnt[c] <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                row_en   <= CFG_ROW_EN;
                grp_num  <= CFG_GRP_NUM;
                ERR_LST  <= 1'b0;
                col_done <= '0;
                for (int c = 0; c < PE_COL; c++) grp_cnt[c] <= '0;
            end else begin
                if (|lst_bad) ERR_LST <= 1'b1;
                for (int c = 0; c < PE_COL; c++) begin
                    if (run && row_en == '0) begin
                        col_done[c] <= 1'b1;
                    end else if (fire[c] && ACT_LST[c]) begin
                        if (grp_cnt[c] == grp_num) col_done[c] <= 1'b1;
                        else grp_cnt[c] <= grp_cnt[c] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        DONE      = 1'b0;
        unique case (state)
            S_IDLE:  if (CFG_START) state_nxt = S_RUN;
            S_RUN:   if (&col_done) state_nxt = S_DRAIN;
            S_DRAIN: if (&empty) begin
                state_nxt = S_IDLE;
                DONE      = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eeg_pea_feed.sv
// tb_eeg_pea_feed: randomized stimulus against a queue-based model of the
// dispatcher; every output is compared on the falling clock edge.
module tb_eeg_pea_feed;

    localparam int PR = 4, PC = 4, AD = 8, WD = 8, AI = 12, WI = 3;
    localparam int FD = 4, GD = 8;
    localparam int PN = PR * PC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, cfg_start, is_idle, done, err_lst;
    logic [PR-1:0]     cfg_row_en;
    logic [GD-1:0]     cfg_grp_num;
    logic [PC-1:0]     act_vld, act_rdy, act_lst;
    logic [PC*AD-1:0]  act_dat;
    logic [PC*AI-1:0]  act_inf;
    logic [PN-1:0]     wei_vld, wei_rdy, wei_lst;
    logic [PN*WD-1:0]  wei_dat;
    logic [PN*WI-1:0]  wei_inf;
    logic [PN-1:0]     pe_din_vld, pe_din_rdy, pe_lst;
    logic [PN*AD-1:0]  pe_act_dat;
    logic [PN*WD-1:0]  pe_wei_dat;
    logic [PN*AI-1:0]  pe_act_inf;
    logic [PN*WI-1:0]  pe_wei_inf;

    eeg_pea_feed #(
        .PE_ROW(PR), .PE_COL(PC), .ACT_DW(AD), .WEI_DW(WD),
        .ACT_IW(AI), .WEI_IW(WI), .FIFO_DEPTH(FD), .GRP_DW(GD)
    ) dut (
        .clk(clk), .rst(rst),
        .CFG_START(cfg_start), .CFG_ROW_EN(cfg_row_en),
        .CFG_GRP_NUM(cfg_grp_num),
        .IS_IDLE(is_idle), .DONE(done), .ERR_LST(err_lst),
        .ACT_VLD(act_vld), .ACT_RDY(act_rdy), .ACT_LST(act_lst),
        .ACT_DAT(act_dat), .ACT_INF(act_inf),
        .WEI_VLD(wei_vld), .WEI_RDY(wei_rdy), .WEI_LST(wei_lst),
        .WEI_DAT(wei_dat), .WEI_INF(wei_inf),
        .PE_DIN_VLD(pe_din_vld), .PE_DIN_RDY(pe_din_rdy),
        .PE_ACT_DAT(pe_act_dat), .PE_WEI_DAT(pe_wei_dat),
        .PE_ACT_INF(pe_act_inf), .PE_WEI_INF(pe_wei_inf),
        .PE_LST(pe_lst)
    );

    int n_cmp = 0, n_bad = 0;

    // reference model: one queue per PE plus run-level bookkeeping
    logic [31:0]   mq [PN][$];
    int            ms;
    logic [PR-1:0] mmask;
    int            mgrp;
    int            mcnt [PC];
    bit            mdone [PC];
    bit            merr;

    int            seq [PC];
    logic [PR-1:0] g_mask;
    int g_grp, g_glen, g_vld, g_rdy, g_blk, g_badc, g_badr, g_cyc;
    int n_done, bp_fires;
    logic [PN-1:0] wrdy_acc;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PN; i++) mq[i].delete();
        ms = 0; mmask = '0; mgrp = 0; merr = 0;
        for (int c = 0; c < PC; c++) begin
            mcnt[c] = 0; mdone[c] = 0;
        end
    endtask

    task automatic drive(input bit start, input bit rs);
        rst         = rs;
        cfg_start   = start;
        cfg_row_en  = g_mask;
        cfg_grp_num = GD'(g_grp);
        for (int c = 0; c < PC; c++) begin
            act_vld[c] = $urandom_range(99) < g_vld;
            act_dat[c*AD +: AD] = AD'(seq[c]);
            act_inf[c*AI +: AI] = AI'(seq[c] * 5 + c);
            act_lst[c] = (seq[c] % g_glen) == (g_glen - 1);
            for (int r = 0; r < PR; r++) begin
                int i = c * PR + r;
                wei_vld[i] = $urandom_range(99) < g_vld;
                wei_dat[i*WD +: WD] = WD'($urandom);
                wei_inf[i*WI +: WI] = WI'($urandom);
                wei_lst[i] = act_lst[c]
                    ^ (c == g_badc && r == g_badr && act_lst[c]);
                pe_din_rdy[i] = ($urandom_range(99) < g_rdy)
                    && !(i == g_blk && g_cyc < 12);
            end
        end
    endtask

    task automatic check_update();
        logic [PC-1:0] e_ar;
        logic [PN-1:0] e_wr, e_pv;
        logic [31:0]   obs;
        bit all_e, all_d, bad;
        all_e = 1; all_d = 1; bad = 0;
        e_wr = '0;
        for (int i = 0; i < PN; i++) begin
            e_pv[i] = mq[i].size() != 0;
            if (mq[i].size() != 0) all_e = 0;
        end
        for (int c = 0; c < PC; c++) begin
            bit ok;
            if (!mdone[c]) all_d = 0;
            ok = (ms == 1) && !mdone[c] && (mmask != 0) && act_vld[c];
            for (int r = 0; r < PR; r++)
                if (mmask[r])
                    ok = ok && wei_vld[c*PR+r] && mq[c*PR+r].size() < FD;
            e_ar[c] = ok;
            for (int r = 0; r < PR; r++) e_wr[c*PR+r] = ok && mmask[r];
        end
        chk("act_rdy", act_rdy, e_ar);
        chk("wei_rdy", wei_rdy, e_wr);
        chk("pe_vld", pe_din_vld, e_pv);
        chk("is_idle", is_idle, ms == 0);
        chk("done", done, ms == 2 && all_e);
        chk("err_lst", err_lst, merr);
        for (int i = 0; i < PN; i++)
            if (mq[i].size() != 0) begin
                obs = {pe_lst[i], pe_wei_inf[i*WI +: WI],
                       pe_act_inf[i*AI +: AI], pe_wei_dat[i*WD +: WD],
                       pe_act_dat[i*AD +: AD]};
                chk($sformatf("head%0d", i), obs, mq[i][0]);
            end
        if (done) n_done++;
        if (g_cyc < 12 && act_rdy[0]) bp_fires++;
        wrdy_acc |= wei_rdy;

        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < PN; i++)
                if (mq[i].size() != 0 && pe_din_rdy[i]) void'(mq[i].pop_front());
            for (int c = 0; c < PC; c++)
                if (e_ar[c]) begin
                    for (int r = 0; r < PR; r++) begin
                        int i = c * PR + r;
                        if (mmask[r]) begin
                            mq[i].push_back({act_lst[c], wei_inf[i*WI +: WI],
                                act_inf[c*AI +: AI], wei_dat[i*WD +: WD],
                                act_dat[c*AD +: AD]});
                            if (wei_lst[i] != act_lst[c]) bad = 1;
                        end
                    end
                    seq[c]++;
                end
            if (ms == 0 && cfg_start) begin
                merr = 0;
                for (int c = 0; c < PC; c++) begin
                    mcnt[c] = 0; mdone[c] = 0;
                end
            end else begin
                if (bad) merr = 1;
                for (int c = 0; c < PC; c++)
                    if (ms == 1 && mmask == 0) mdone[c] = 1;
                    else if (e_ar[c] && act_lst[c]) begin
                        if (mcnt[c] == mgrp) mdone[c] = 1;
                        else mcnt[c]++;
                    end
            end
            case (ms)
                0: if (cfg_start) begin
                    ms = 1; mmask = cfg_row_en; mgrp = int'(cfg_grp_num);
                end
                1: if (all_d) ms = 2;
                default: if (all_e) ms = 0;
            endcase
        end
        g_cyc++;
    endtask

    task automatic step(input bit start, input bit rs);
        @(posedge clk);
        #1;
        drive(start, rs);
        @(negedge clk);
        check_update();
    endtask

    task automatic run_case(input logic [PR-1:0] mask, input int grp,
                            input int glen, input int vld, input int rdy,
                            input int blk, input int badc, input int badr,
                            input int rst_at, input int exp_done);
        g_mask = mask; g_grp = grp; g_glen = glen; g_vld = vld;
        g_rdy = rdy; g_blk = blk; g_badc = badc; g_badr = badr;
        for (int c = 0; c < PC; c++) seq[c] = 0;
        n_done = 0; bp_fires = 0; wrdy_acc = '0; g_cyc = 0;
        step(1, 0);
        for (int k = 1; k < 3000 && ms != 0; k++) step(0, k == rst_at);
        if (ms != 0) chk("timeout", 64'(ms), 0);
        step(0, 0);
        step(0, 0);
        chk("done_cnt", 64'(n_done), 64'(exp_done));
        chk("dis_wrdy", wrdy_acc & ~{PC{mask}}, 0);
        if (blk >= 0) chk("bp_fires", 64'(bp_fires), 4);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_row_en = '0; cfg_grp_num = '0;
        act_vld = '0; act_lst = '0; act_dat = '0; act_inf = '0;
        wei_vld = '0; wei_lst = '0; wei_dat = '0; wei_inf = '0;
        pe_din_rdy = '0;
        g_mask = '0; g_grp = 0; g_glen = 1; g_vld = 0; g_rdy = 0;
        g_blk = -1; g_badc = -1; g_badr = -1; g_cyc = 100;
        for (int c = 0; c < PC; c++) seq[c] = 0;
        model_reset();
        step(0, 1);
        step(0, 1);
        chk("rst_status", {is_idle, done, err_lst}, 3'b100);
        chk("rst_vld_rdy", {act_rdy, wei_rdy, pe_din_vld}, 0);

        run_case(4'b1111, 0, 3, 100, 100, -1, -1, -1, 0, 1);
        run_case(4'b0101, 0, 3, 100, 100, -1, -1, -1, 0, 1);
        run_case(4'b1111, 0, 8, 100, 100, 2, -1, -1, 0, 1);
        run_case(4'b1111, 0, 20, 100, 50, -1, -1, -1, 0, 1);
        run_case(4'b1111, 0, 3, 100, 100, -1, 1, 3, 0, 1);
        chk("err_sticky", err_lst, 1);
        run_case(4'b1111, 2, 3, 70, 80, -1, -1, -1, 0, 1);
        chk("err_cleared", err_lst, 0);
        run_case(4'b1111, 2, 3, 100, 60, -1, -1, -1, 8, 0);
        chk("rst_mid_vld", pe_din_vld, 0);
        chk("rst_mid_idle", is_idle, 1);
        run_case(4'b0000, 1, 2, 100, 100, -1, -1, -1, 0, 1);
        for (int n = 0; n < 4; n++)
            run_case(PR'($urandom), $urandom_range(2), $urandom_range(4, 1),
                     $urandom_range(100, 50), $urandom_range(100, 30),
                     -1, -1, -1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
